multdiv_unit: RTL and testbench

- Iterative signed 32-bit multiply/divide unit, fed directly by the execute stage of the pipelined processor.
- Execute-stage operands go in as data_operandA and data_operandB; start pulses go in as ctrl_MULT and ctrl_DIV.
- The processor holds its pipeline stalled until data_resultRDY. It then writes data_result to rd of the mult/div instruction.
- data_exception feeds the processor's rstatus exception path.

---
 rtl/multdiv_unit_if.sv | 39 +++
 rtl/multdiv_unit.sv | 245 ++++++++++++++++++++++++
 tb/tb_multdiv_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/multdiv_unit_if.sv
// Execute-stage <-> multiply/divide unit connection: operands, start pulses, result and status.
// Latency: none (wires only).
// Backpressure: none; the pipeline stalls on busy and resumes on data_resultRDY.
interface multdiv_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    // Execute stage side: supplies operands and start pulses, consumes result.
    modport master (
        output data_operandA,
        output data_operandB,
        output ctrl_MULT,
        output ctrl_DIV,
        input  data_result,
        input  data_exception,
        input  data_resultRDY,
        input  busy
    );

    // Unit side.
    modport slave (
        input  data_operandA,
        input  data_operandB,
        input  ctrl_MULT,
        input  ctrl_DIV,
        output data_result,
        output data_exception,
        output data_resultRDY,
        output busy
    );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (radix-4 Booth) / divide (restoring) unit.
// Latency: MULT completes 17 edges after start, DIV 34 edges; RDY pulses the cycle after.
// Backpressure: none; a new start at any time aborts the current op and restarts.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    multdiv_unit_if.slave mdu
);

    localparam int W = WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Terminal counts: last Booth step, and the sign-fix cycle of a divide.
    localparam logic [5:0] MULT_LAST = 6'd15;
    localparam logic [5:0] DIV_FIX  = 6'd32;

    state_t state_q, state_d;

    // Shared datapath: P is the Booth accumulator / division remainder,
    // Q is the multiplier / dividend-then-quotient, M the multiplicand / |divisor|.
    logic [W:0]   p_q,   p_d;
    logic [W-1:0] q_q,   q_d;
    logic         qm1_q, qm1_d;
    logic [W-1:0] m_q,   m_d;
    logic [5:0]   cnt_q, cnt_d;

    // Per-operation flags captured at start.
    logic is_div_q, is_div_d;
    logic neg_q,    neg_d;
    logic div0_q,   div0_d;
    logic ovf_q,    ovf_d;

    // Architected outputs; only change at completion or reset.
    logic [W-1:0] res_q, res_d;
    logic         exc_q, exc_d;
    logic         rdy_q, rdy_d;

    // Control strobes from the FSM output process.
    logic start_mult;
    logic start_div;
    logic mult_step;
    logic div_step;
    logic sign_fix;
    logic finish;

    // Datapath helper signals.
    logic [W-1:0] abs_a;
    logic [W-1:0] abs_b;
    logic [W+2:0] m_ext;
    logic [W+2:0] booth_add;
    logic [W+2:0] booth_sum;
    logic [W:0]   div_shift;
    logic [W:0]   div_trial;
    logic [W:0]   prod_hi;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a start pulse always wins (MULT over DIV), otherwise walk the op.
    always_comb begin
        state_d = state_q;
        if (mdu.ctrl_MULT) begin
            state_d = ST_MULT;
        end else if (mdu.ctrl_DIV) begin
            state_d = ST_DIV;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_MULT: if (cnt_q == MULT_LAST) state_d = ST_DONE;
                ST_DIV:  if (cnt_q == DIV_FIX)   state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: one datapath strobe per cycle; a start suppresses everything else.
    always_comb begin
        start_mult = 1'b0;
        start_div  = 1'b0;
        mult_step  = 1'b0;
        div_step   = 1'b0;
        sign_fix   = 1'b0;
        finish     = 1'b0;
        if (mdu.ctrl_MULT) begin
            start_mult = 1'b1;
        end else if (mdu.ctrl_DIV) begin
            start_div = 1'b1;
        end else begin
            case (state_q)
                ST_MULT: mult_step = 1'b1;
                ST_DIV: begin
                    if (cnt_q == DIV_FIX) sign_fix = 1'b1;
                    else                  div_step = 1'b1;
                end
                ST_DONE: finish = 1'b1;
                default: ;
            endcase
        end
    end

    // Operand magnitudes for the divider.
    assign abs_a = mdu.data_operandA[W-1] ? (~mdu.data_operandA + 1'b1) : mdu.data_operandA;
    assign abs_b = mdu.data_operandB[W-1] ? (~mdu.data_operandB + 1'b1) : mdu.data_operandB;

    // Booth digit select: two guard bits above P so that +/-2M never overflows the add.
    assign m_ext = {{3{m_q[W-1]}}, m_q};
    always_comb begin
        booth_add = '0;
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: booth_add = m_ext;
            3'b011:         booth_add = m_ext << 1;
            3'b100:         booth_add = ~(m_ext << 1) + 1'b1;
            3'b101, 3'b110: booth_add = ~m_ext + 1'b1;
            default:        booth_add = '0;
        endcase
    end
    assign booth_sum = {{2{p_q[W]}}, p_q} + booth_add;

    // Restoring step: shift the next dividend bit into the remainder and trial-subtract.
    assign div_shift = {p_q[W-1:0], q_q[W-1]};
    assign div_trial = div_shift - {1'b0, m_q};

    // Bits 63..31 of the product; all equal means it fits in signed 32 bits.
    assign prod_hi = {p_q[W-1:0], q_q[W-1]};

    // Datapath next-state: load on start, iterate, sign-fix, publish on finish.
    always_comb begin
        p_d      = p_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        res_d    = res_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        if (start_mult) begin
            p_d      = '0;
            q_d      = mdu.data_operandB;
            qm1_d    = 1'b0;
            m_d      = mdu.data_operandA;
            cnt_d    = '0;
            is_div_d = 1'b0;
            neg_d    = 1'b0;
            div0_d   = 1'b0;
            ovf_d    = 1'b0;
        end else if (start_div) begin
            p_d      = '0;
            q_d      = abs_a;
            qm1_d    = 1'b0;
            m_d      = abs_b;
            cnt_d    = '0;
            is_div_d = 1'b1;
            neg_d    = mdu.data_operandA[W-1] ^ mdu.data_operandB[W-1];
            div0_d   = (mdu.data_operandB == '0);
            ovf_d    = (mdu.data_operandA == {1'b1, {(W-1){1'b0}}}) &&
                       (mdu.data_operandB == {W{1'b1}});
        end else if (mult_step) begin
            // Arithmetic shift of {sum, Q, q-1} right by two.
            p_d   = booth_sum[W+2:2];
            q_d   = {booth_sum[1:0], q_q[W-1:2]};
            qm1_d = q_q[1];
            cnt_d = cnt_q + 6'd1;
        end else if (div_step) begin
            if (!div_trial[W]) begin
                p_d = div_trial;
                q_d = {q_q[W-2:0], 1'b1};
            end else begin
                p_d = div_shift;
                q_d = {q_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q + 6'd1;
        end else if (sign_fix) begin
            // Truncation toward zero: negate the magnitude quotient when signs differ.
            if (neg_q) q_d = ~q_q + 1'b1;
            cnt_d = cnt_q + 6'd1;
        end else if (finish) begin
            rdy_d = 1'b1;
            if (is_div_q) begin
                res_d = div0_q ? '0 : q_q;
                exc_d = div0_q | ovf_q;
            end else begin
                res_d = q_q;
                exc_d = !((&prod_hi) || (prod_hi == '0));
            end
        end
    end

    // Datapath and output registers; reset clears everything and kills any pending RDY.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_q      <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            m_q      <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            res_q    <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            p_q      <= p_d;
            q_q      <= q_d;
            qm1_q    <= qm1_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    // All outputs come straight from registers; busy drops as the unit returns to IDLE with RDY.
    assign mdu.data_result    = res_q;
    assign mdu.data_exception = exc_q;
    assign mdu.data_resultRDY = rdy_q;
    assign mdu.busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed testbench for multdiv_unit: hand-computed products/quotients, latency and restart checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_multdiv_unit;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    logic [31:0] prev_res;
    int   early_rdy;

    multdiv_unit_if #(.WIDTH(32)) mdu_if ();

    multdiv_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .mdu   (mdu_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse on a negedge; returns #1 after the start edge with junk operands applied.
    task automatic start_op(input logic mul, input logic dv, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        mdu_if.ctrl_MULT     = mul;
        mdu_if.ctrl_DIV      = dv;
        mdu_if.data_operandA = a;
        mdu_if.data_operandB = b;
        @(posedge clock);
        #1;
        mdu_if.ctrl_MULT     = 1'b0;
        mdu_if.ctrl_DIV      = 1'b0;
        mdu_if.data_operandA = 32'hDEADBEEF;
        mdu_if.data_operandB = 32'h0BADF00D;
    endtask

    // Count edges from the start edge until RDY is seen (bounded), then check everything.
    task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res, input logic exp_exc);
        int  n;
        logic got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(posedge clock);
            n++;
            #1;
            if (n == 5) begin
                chk({tag, " busy_mid"}, {31'd0, mdu_if.busy}, 32'd1);
                chk({tag, " held_res"}, mdu_if.data_result, prev_res);
            end
            if (mdu_if.data_resultRDY) got = 1'b1;
        end
        chk({tag, " latency"}, n, exp_lat);
        chk({tag, " result"}, mdu_if.data_result, exp_res);
        chk({tag, " exception"}, {31'd0, mdu_if.data_exception}, {31'd0, exp_exc});
        chk({tag, " busy_rdy"}, {31'd0, mdu_if.busy}, 32'd0);
        @(posedge clock);
        #1;
        chk({tag, " rdy_1cyc"}, {31'd0, mdu_if.data_resultRDY}, 32'd0);
        prev_res = exp_res;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        prev_res = 32'd0;
        reset    = 1'b0;
        mdu_if.ctrl_MULT     = 1'b0;
        mdu_if.ctrl_DIV      = 1'b0;
        mdu_if.data_operandA = 32'd0;
        mdu_if.data_operandB = 32'd0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst result", mdu_if.data_result, 32'd0);
        chk("rst exc", {31'd0, mdu_if.data_exception}, 32'd0);
        chk("rst rdy", {31'd0, mdu_if.data_resultRDY}, 32'd0);
        chk("rst busy", {31'd0, mdu_if.busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Multiply
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
        wait_done("mul 7*-3", 17, 32'hFFFFFFEB, 1'b0);
        start_op(1'b1, 1'b0, 32'h00010000, 32'h00010000);
        wait_done("mul 2^16*2^16", 17, 32'h00000000, 1'b1);
        start_op(1'b1, 1'b0, 32'h7FFFFFFF, 32'd2);
        wait_done("mul max*2", 17, 32'hFFFFFFFE, 1'b1);
        start_op(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF);
        wait_done("mul min*-1", 17, 32'h80000000, 1'b1);

        // Divide
        start_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
        wait_done("div -7/2", 34, 32'hFFFFFFFD, 1'b0);
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        wait_done("div 100/7", 34, 32'd14, 1'b0);
        start_op(1'b0, 1'b1, 32'hFFFFFF9C, 32'd7);
        wait_done("div -100/7", 34, 32'hFFFFFFF2, 1'b0);
        start_op(1'b0, 1'b1, 32'd5, 32'd0);
        wait_done("div 5/0", 34, 32'd0, 1'b1);
        start_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div min/-1", 34, 32'h80000000, 1'b1);

        // Restart: DIV aborted by MULT at edge 10
        early_rdy = 0;
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clock);
            #1;
            if (mdu_if.data_resultRDY) early_rdy++;
        end
        start_op(1'b1, 1'b0, 32'd6, 32'd7);
        wait_done("restart mul 6*7", 17, 32'd42, 1'b0);
        chk("restart no div rdy", early_rdy, 32'd0);

        // Simultaneous pulses: MULT wins
        start_op(1'b1, 1'b1, 32'd6, 32'd3);
        wait_done("both 6,3", 17, 32'd18, 1'b0);

        // Async reset mid-multiply
        start_op(1'b1, 1'b0, 32'd5, 32'd5);
        repeat (8) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("arst result", mdu_if.data_result, 32'd0);
        chk("arst exc", {31'd0, mdu_if.data_exception}, 32'd0);
        chk("arst rdy", {31'd0, mdu_if.data_resultRDY}, 32'd0);
        chk("arst busy", {31'd0, mdu_if.busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        early_rdy = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (mdu_if.data_resultRDY) early_rdy++;
        end
        chk("arst no rdy", early_rdy, 32'd0);
        prev_res = 32'd0;
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        wait_done("post-rst mul 3*4", 17, 32'd12, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
